// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch path
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_RUN   = 2'd1,
    FETCH_FAULT = 2'd2
  } fetch_state_e;

  localparam int          INSTR_BYTES   = 4;
  localparam logic [63:0] DEF_RESET_PC  = 64'd0;
  localparam int          DEF_MEM_BYTES = 4096;

endpackage

// File: rtl/fetch_addr_check.sv
// rtl/fetch_addr_check.sv - word-alignment and range check for a fetch address
module fetch_addr_check
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = 64,
  parameter int MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic [ADDR_W-1:0] i_pc,
  output logic              o_legal
);

  // One extra bit so the last-byte address cannot wrap past zero
  logic [ADDR_W:0] w_last_byte;

  assign w_last_byte = {1'b0, i_pc} + (ADDR_W+1)'(INSTR_BYTES - 1);
  assign o_legal     = (i_pc[1:0] == 2'b00) && (w_last_byte < (ADDR_W+1)'(MEM_BYTES));

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - PC owner and instruction fetch sequencer feeding decode
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEF_RESET_PC),
  parameter int                MEM_BYTES = DEF_MEM_BYTES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [31:0]       dec_instr,
  output logic [ADDR_W-1:0] dec_pc,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_pc,
  output logic [31:0]       fetch_count
);

  fetch_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_infl_v;
  logic [ADDR_W-1:0] r_infl_pc;
  logic              r_dec_valid;
  logic [31:0]       r_dec_instr;
  logic [ADDR_W-1:0] r_dec_pc;
  logic              r_fault;
  logic [ADDR_W-1:0] r_fault_pc;
  logic [31:0]       r_fetch_count;

  logic w_legal, w_accept, w_replay, w_issue, w_fault_set, w_handshake;

  fetch_addr_check #(
    .ADDR_W   (ADDR_W),
    .MEM_BYTES(MEM_BYTES)
  ) u_addr_check (
    .i_pc   (r_fetch_pc),
    .o_legal(w_legal)
  );

  assign w_accept    = r_infl_v && (!r_dec_valid || dec_ready);
  assign w_replay    = r_infl_v && !w_accept;
  assign w_handshake = r_dec_valid && dec_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= FETCH_IDLE;
    else        r_state <= w_state_nxt;
  end

  // A pending replay outranks the fault check so the stalled word is refetched first
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_fault_set = 1'b0;
    if (redirect_valid) begin
      w_state_nxt = fetch_en ? FETCH_RUN : FETCH_IDLE;
    end else begin
      case (r_state)
        FETCH_IDLE: if (fetch_en) w_state_nxt = FETCH_RUN;
        FETCH_RUN: begin
          if (!fetch_en) begin
            w_state_nxt = FETCH_IDLE;
          end else if (!w_replay) begin
            if (w_legal) begin
              w_issue = 1'b1;
            end else begin
              w_fault_set = 1'b1;
              w_state_nxt = FETCH_FAULT;
            end
          end
        end
        FETCH_FAULT: w_state_nxt = FETCH_FAULT;
        default:     w_state_nxt = FETCH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc    <= RESET_PC;
      r_infl_v      <= 1'b0;
      r_infl_pc     <= '0;
      r_dec_valid   <= 1'b0;
      r_dec_instr   <= '0;
      r_dec_pc      <= '0;
      r_fault       <= 1'b0;
      r_fault_pc    <= '0;
      r_fetch_count <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc  <= redirect_target;
      r_infl_v    <= 1'b0;
      r_dec_valid <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_infl_v <= w_issue;
      if (w_replay) begin
        r_fetch_pc <= r_infl_pc;
      end else if (w_issue) begin
        r_infl_pc  <= r_fetch_pc;
        r_fetch_pc <= r_fetch_pc + ADDR_W'(INSTR_BYTES);
      end
      if (w_accept) begin
        r_dec_valid <= 1'b1;
        r_dec_instr <= imem_rdata;
        r_dec_pc    <= r_infl_pc;
      end else if (w_handshake) begin
        r_dec_valid <= 1'b0;
      end
      if (w_fault_set) begin
        r_fault    <= 1'b1;
        r_fault_pc <= r_fetch_pc;
      end
      if (w_handshake) r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

  assign imem_addr   = r_fetch_pc;
  assign dec_valid   = r_dec_valid;
  assign dec_instr   = r_dec_instr;
  assign dec_pc      = r_dec_pc;
  assign fault       = r_fault;
  assign fault_pc    = r_fault_pc;
  assign fetch_count = r_fetch_count;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Drives `instructionAddress` of `instruction_memory` and sequences instruction fetch for the decoder.
- Owns the 64-bit program counter and absorbs the memory's one-cycle registered read latency.
- Presents a valid/ready instruction stream with its PC to decode, and accepts branch redirects (`CBZ`/`B`) from execute.
- Flags misaligned or out-of-range fetch addresses.

Parameters:
- ADDR_W, 64, width of PC and memory address.
- RESET_PC, 0, first fetch address after reset.
- MEM_BYTES, 4096, byte size of instruction memory; valid fetch requires PC+3 < MEM_BYTES.

Ports:
- clk  in  1  system clock, rising edge; shared with instruction_memory.
- rst_n  in  1  reset, asynchronous, active-low.
- fetch_en  in  1  1 = issue fetches; 0 = stop issuing (in-flight fetch still completes).
- imem_addr  out  ADDR_W  to instruction_memory instructionAddress.
- imem_rdata  in  32  instruction_memory instruction; holds data for the address sampled at the previous posedge.
- dec_valid  out  1  dec_instr/dec_pc valid.
- dec_ready  in  1  decoder accepts this cycle.
- dec_instr  out  32  fetched instruction.
- dec_pc  out  ADDR_W  address of dec_instr.
- redirect_valid  in  1  taken branch; flush and refetch.
- redirect_target  in  ADDR_W  branch target byte address.
- fault  out  1  sticky fetch-address fault.
- fault_pc  out  ADDR_W  offending address.
- fetch_count  out  32  count of dec handshakes, wraps at 2^32.

Behaviour:
- Clock and reset:
  - One clock: clk.
  - Reset rst_n is asynchronous, active-low.
  - Reset values: imem_addr=RESET_PC, dec_valid=0, dec_instr=0, dec_pc=0, fault=0, fault_pc=0, fetch_count=0, state=IDLE, infl_v=0.
- Internal registers:
  - fetch_pc drives imem_addr.
  - infl_v/infl_pc record that imem_rdata next cycle belongs to infl_pc.
- Issue rule:
  - Issue when state=RUN, fetch_en=1, no redirect, no replay, and fetch_pc legal.
  - On issue: infl_v<=1, infl_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^ADDR_W).
  - Otherwise infl_v<=0.
- Legal address: fetch_pc[1:0]==0 and fetch_pc+3 < MEM_BYTES.
- Accept rule:
  - accept = infl_v && (!dec_valid || dec_ready).
  - On accept: dec_valid<=1, dec_instr<=imem_rdata, dec_pc<=infl_pc.
  - If dec_valid && dec_ready && !accept: dec_valid<=0.
- Backpressure:
  - infl_v && !accept forces a replay: fetch_pc<=infl_pc, no issue that cycle, infl_v<=0.
  - Cost: one bubble after dec_ready returns. No instruction is lost or duplicated.
- Throughput: one instruction per cycle with dec_ready held high; first dec_valid 2 cycles after entering RUN.
- Redirect (highest priority, any state except reset):
  - fetch_pc<=redirect_target, infl_v<=0, dec_valid<=0, even if dec_ready=1 that cycle.
  - A handshake in the same cycle is NOT counted.
  - Clears fault; state<=RUN if fetch_en else IDLE.
- FSM:
  - IDLE: fetch_en=1 -> RUN.
  - RUN: fetch_en=0 -> IDLE; illegal fetch_pc with fetch_en=1 -> FAULT (fault<=1, fault_pc<=fetch_pc, no issue).
  - FAULT: no issue; dec output still drains via dec_ready; exits only by redirect or reset.
- fetch_en deassert mid-stream: pending dec_valid and in-flight data still delivered; a replay in IDLE leaves fetch_pc at infl_pc for resume.
- fetch_count increments on every dec_valid && dec_ready, except in redirect cycles.
- Reset mid-operation: all state returns to reset values immediately; the stale imem_rdata is discarded because infl_v=0.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding FETCH_IDLE/FETCH_RUN/FETCH_FAULT;
  - INSTR_BYTES=4;
  - default RESET_PC and MEM_BYTES.
- One combinational sub-module, fetch_addr_check (inputs: pc; output: legal), reused later by the data-memory path.
- Everything else is flat.

Test Plan:
- Reset, fetch_en=1, dec_ready=1 -> dec_valid rises on cycle 2 with dec_pc=0, dec_instr=0xAB020020; next cycle dec_pc=4, dec_instr=0xB1002020; then PC 8, 12, ... one per cycle.
- Hold dec_ready=0 for 3 cycles while dec_pc=4 -> dec_instr stays 0xB1002020, imem_addr oscillates 8/12 via replay; after release dec_pc=8 (0xEB020020) follows after one bubble; fetch_count has no gaps or duplicates.
- At dec_pc=36 (0xB4000041), assert redirect_valid with target 44 -> next dec_valid carries dec_pc=44; PC 40 (0x14000002) is never presented; the flushed handshake is not counted.
- Redirect to 0x6 -> fault=1, fault_pc=6, no dec_valid afterwards; redirect to 0 -> fault=0, stream restarts at PC 0.
- Run sequentially to 4092 -> PC 4092 delivered, then fault with fault_pc=4096.
- Pull rst_n low mid-stream, asynchronously between edges -> outputs zero immediately, imem_addr=0; after release, fetch resumes at PC 0.
